// File: rtl/umul_bi_job_ctrl_if.sv
// ---------------------------------------------------------------------------
// umul_bi_job_ctrl_if
// Job request / result handshake bundle for the bipolar stochastic multiplier
// job controller.
//   in_valid / in_ready : job request handshake, carries operands in_a, in_b
//   out_valid / out_ready : result handshake, carries out_ones and out_prod
//   out_ones  : number of ones counted in the output stream (0..2**INWD)
//   out_prod  : signed bipolar product scaled by 2**INWD (2*out_ones - N)
// Modports:
//   master : the job producer / result consumer side
//   slave  : the controller side
// ---------------------------------------------------------------------------
interface umul_bi_job_ctrl_if #(
  parameter int INWD = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INWD-1:0]        in_a;
  logic [INWD-1:0]        in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [INWD:0]          out_ones;
  logic signed [INWD+1:0] out_prod;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_ones, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_ones, out_prod
  );
endinterface

// File: rtl/umul_bi_job_ctrl.sv
// ---------------------------------------------------------------------------
// umul_bi_job_ctrl
// Sequences one job on a bipolar stochastic multiplier: latches operands A/B,
// loads B into the multiplier for one cycle, then streams N = 2**INWD bits
// iA = (A > rng) while counting the multiplier's output ones, and finally
// presents the ones count and the signed bipolar product 2*ones - N.
// Ports:
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   job           : request/result handshake bundle (slave side)
//   abort         : drop the current job and return to IDLE
//   rng           : external random number, advanced when rng_en is high
//   rng_en        : advance the external RNG this cycle
//   mul_iA        : stream bit to the multiplier
//   mul_iB        : operand B to the multiplier, qualified by mul_loadB
//   mul_loadB     : load strobe for mul_iB
//   mul_oC        : multiplier output bit (combinational from mul_iA)
// ---------------------------------------------------------------------------
module umul_bi_job_ctrl #(
  parameter int INWD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  umul_bi_job_ctrl_if.slave job,
  input  logic              abort,
  input  logic [INWD-1:0]   rng,
  output logic              rng_en,
  output logic              mul_iA,
  output logic [INWD-1:0]   mul_iB,
  output logic              mul_loadB,
  input  logic              mul_oC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // N expressed at product width; the cycle counter ends at all-ones (N-1)
  localparam logic [INWD+1:0] N_EXT    = (INWD+2)'(1) << INWD;
  localparam logic [INWD-1:0] CNT_LAST = {INWD{1'b1}};

  state_t          state_q, state_d;
  logic [INWD-1:0] a_q, a_d;
  logic [INWD-1:0] b_q, b_d;
  logic [INWD:0]   ones_q, ones_d;
  logic [INWD-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. abort is applied last so it overrides every state,
  // including an acceptance in IDLE and a result handshake in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (job.in_valid) begin
          a_d     = job.in_a;
          b_d     = job.in_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ones_d  = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // ones counter is one bit wider than the cycle counter so an
        // all-ones stream reaches N without wrapping
        ones_d = ones_q + (INWD+1)'(mul_oC);
        cnt_d  = cnt_q + INWD'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (job.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      ones_d  = '0;
      cnt_d   = '0;
    end
  end

  // Outputs decode directly from the state register. Result fields are
  // gated by DONE so every output reads zero outside a valid result.
  always_comb begin
    job.in_ready  = (state_q == IDLE);
    job.out_valid = (state_q == DONE);
    job.out_ones  = '0;
    job.out_prod  = '0;
    if (state_q == DONE) begin
      job.out_ones = ones_q;
      job.out_prod = $signed({ones_q, 1'b0} - N_EXT);
    end
    mul_loadB = (state_q == LOAD);
    mul_iB    = (state_q == IDLE) ? '0 : b_q;
    rng_en    = (state_q == RUN);
    mul_iA    = (state_q == RUN) && (a_q > rng);
  end

endmodule
